// File: rtl/lazy_job_controller.sv
// Job-level controller for the lazy match/summary pipeline: issues one window request
// at a time, turns each summary into a sequence and carries match overlap into the next job.
module lazy_job_controller #(
  parameter int JOB_LEN         = 64,
  parameter int JOB_LEN_LOG2    = 6,
  parameter int LAZY_LEN        = 4,
  parameter int MATCH_LEN_WIDTH = 8,
  parameter int SEQ_OFFSET_BITS = 16,
  parameter int SEQ_LL_BITS     = 16,
  parameter int SEQ_ML_BITS     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_job_valid,
  output logic                       o_job_ready,
  input  logic                       i_job_delim,
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  output logic [JOB_LEN_LOG2-1:0]    o_req_match_head_ptr,
  output logic [JOB_LEN_LOG2-1:0]    o_req_seq_head_ptr,
  output logic                       o_req_delim,
  input  logic                       i_summary_done,
  input  logic [JOB_LEN_LOG2-1:0]    i_summary_seq_head_ptr,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  input  logic                       i_summary_move_to_next_job,
  input  logic [JOB_LEN_LOG2-1:0]    i_summary_move_forward,
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_eoj,
  output logic                       o_seq_delim,
  output logic                       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  localparam int HEAD_SUM_W = JOB_LEN_LOG2 + 1;
  localparam int LAZY_SUM_W = MATCH_LEN_WIDTH + 1;

  state_t                       state_r, state_nxt_s;
  logic [JOB_LEN_LOG2-1:0]      seq_head_r, seq_head_nxt_s;
  logic [JOB_LEN_LOG2-1:0]      match_head_r, match_head_nxt_s;
  logic [SEQ_ML_BITS-1:0]       overlap_r, overlap_nxt_s;
  logic                         delim_r, delim_nxt_s;
  logic                         ret_issue_r, ret_issue_nxt_s;
  logic                         req_valid_r, req_valid_nxt_s;
  logic                         seq_valid_r, seq_valid_nxt_s;
  logic                         job_ready_r, busy_r;
  logic [SEQ_LL_BITS-1:0]       seq_ll_r, seq_ll_nxt_s;
  logic [SEQ_ML_BITS-1:0]       seq_ml_r, seq_ml_nxt_s;
  logic [SEQ_OFFSET_BITS-1:0]   seq_offset_r, seq_offset_nxt_s;
  logic                         seq_eoj_r, seq_eoj_nxt_s;
  logic                         seq_delim_r, seq_delim_nxt_s;

  logic [HEAD_SUM_W-1:0]        head_sum_s;
  logic [LAZY_SUM_W-1:0]        lazy_sum_s;
  logic                         lazy_fits_s;
  logic                         overlap_skip_s;
  logic                         no_match_s;
  logic                         unused_s;

  // Head arithmetic is one bit wider so window and advance overflow stay visible.
  assign head_sum_s     = HEAD_SUM_W'(seq_head_r) + HEAD_SUM_W'(i_summary_move_forward);
  assign lazy_sum_s     = LAZY_SUM_W'(match_head_r) + LAZY_SUM_W'(LAZY_LEN);
  assign lazy_fits_s    = (lazy_sum_s < LAZY_SUM_W'(JOB_LEN));
  assign overlap_skip_s = (overlap_r >= SEQ_ML_BITS'(JOB_LEN));
  assign no_match_s     = (i_summary_ml == {SEQ_ML_BITS{1'b0}}) && !i_summary_eoj;
  // The echoed head is only cross-checked outside the design.
  assign unused_s       = ^{i_summary_seq_head_ptr, head_sum_s[JOB_LEN_LOG2]};

  assign o_job_ready          = job_ready_r;
  assign o_busy               = busy_r;
  assign o_req_valid          = req_valid_r;
  assign o_req_seq_head_ptr   = seq_head_r;
  assign o_req_match_head_ptr = match_head_r;
  assign o_req_delim          = delim_r;
  assign o_seq_valid          = seq_valid_r;
  assign o_seq_ll             = seq_ll_r;
  assign o_seq_ml             = seq_ml_r;
  assign o_seq_offset         = seq_offset_r;
  assign o_seq_eoj            = seq_eoj_r;
  assign o_seq_delim          = seq_delim_r;

  // Next-state, pointer, overlap and output-register values.
  always_comb begin
    state_nxt_s      = state_r;
    seq_head_nxt_s   = seq_head_r;
    match_head_nxt_s = match_head_r;
    overlap_nxt_s    = overlap_r;
    delim_nxt_s      = delim_r;
    ret_issue_nxt_s  = ret_issue_r;
    req_valid_nxt_s  = req_valid_r;
    seq_valid_nxt_s  = seq_valid_r;
    seq_ll_nxt_s     = seq_ll_r;
    seq_ml_nxt_s     = seq_ml_r;
    seq_offset_nxt_s = seq_offset_r;
    seq_eoj_nxt_s    = seq_eoj_r;
    seq_delim_nxt_s  = seq_delim_r;
    case (state_r)
      ST_IDLE: begin
        if (i_job_valid) begin
          delim_nxt_s = i_job_delim;
          if (overlap_skip_s) begin
            state_nxt_s = ST_SKIP;
          end else begin
            seq_head_nxt_s   = overlap_r[JOB_LEN_LOG2-1:0];
            match_head_nxt_s = overlap_r[JOB_LEN_LOG2-1:0];
            overlap_nxt_s    = {SEQ_ML_BITS{1'b0}};
            req_valid_nxt_s  = 1'b1;
            state_nxt_s      = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_req_ready) begin
          req_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_summary_done) begin
          if (no_match_s) begin
            if (lazy_fits_s) begin
              // Slide the window; the sequence start stays put.
              match_head_nxt_s = lazy_sum_s[JOB_LEN_LOG2-1:0];
              req_valid_nxt_s  = 1'b1;
              state_nxt_s      = ST_ISSUE;
            end else begin
              seq_ll_nxt_s     = SEQ_LL_BITS'(JOB_LEN) - SEQ_LL_BITS'(seq_head_r);
              seq_ml_nxt_s     = {SEQ_ML_BITS{1'b0}};
              seq_offset_nxt_s = {SEQ_OFFSET_BITS{1'b0}};
              seq_eoj_nxt_s    = 1'b1;
              seq_delim_nxt_s  = delim_r;
              overlap_nxt_s    = {SEQ_ML_BITS{1'b0}};
              ret_issue_nxt_s  = 1'b0;
              seq_valid_nxt_s  = 1'b1;
              state_nxt_s      = ST_EMIT;
            end
          end else if (i_summary_move_to_next_job) begin
            seq_ll_nxt_s     = i_summary_ll;
            seq_ml_nxt_s     = i_summary_ml;
            seq_offset_nxt_s = i_summary_offset;
            seq_eoj_nxt_s    = 1'b1;
            seq_delim_nxt_s  = delim_r;
            // A match never runs across a block boundary.
            overlap_nxt_s    = delim_r ? {SEQ_ML_BITS{1'b0}} : i_summary_overlap_len;
            ret_issue_nxt_s  = 1'b0;
            seq_valid_nxt_s  = 1'b1;
            state_nxt_s      = ST_EMIT;
          end else begin
            seq_ll_nxt_s     = i_summary_ll;
            seq_ml_nxt_s     = i_summary_ml;
            seq_offset_nxt_s = i_summary_offset;
            seq_eoj_nxt_s    = 1'b0;
            seq_delim_nxt_s  = 1'b0;
            seq_head_nxt_s   = head_sum_s[JOB_LEN_LOG2-1:0];
            match_head_nxt_s = head_sum_s[JOB_LEN_LOG2-1:0];
            ret_issue_nxt_s  = 1'b1;
            seq_valid_nxt_s  = 1'b1;
            state_nxt_s      = ST_EMIT;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (i_seq_ready) begin
          seq_valid_nxt_s = 1'b0;
          if (ret_issue_r) begin
            req_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      ST_SKIP: begin
        seq_ll_nxt_s     = {SEQ_LL_BITS{1'b0}};
        seq_ml_nxt_s     = {SEQ_ML_BITS{1'b0}};
        seq_offset_nxt_s = {SEQ_OFFSET_BITS{1'b0}};
        seq_eoj_nxt_s    = 1'b1;
        seq_delim_nxt_s  = delim_r;
        overlap_nxt_s    = delim_r ? {SEQ_ML_BITS{1'b0}} : (overlap_r - SEQ_ML_BITS'(JOB_LEN));
        ret_issue_nxt_s  = 1'b0;
        seq_valid_nxt_s  = 1'b1;
        state_nxt_s      = ST_EMIT;
      end
      default: begin
        req_valid_nxt_s = 1'b0;
        seq_valid_nxt_s = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      seq_head_r   <= {JOB_LEN_LOG2{1'b0}};
      match_head_r <= {JOB_LEN_LOG2{1'b0}};
      overlap_r    <= {SEQ_ML_BITS{1'b0}};
      delim_r      <= 1'b0;
      ret_issue_r  <= 1'b0;
      req_valid_r  <= 1'b0;
      seq_valid_r  <= 1'b0;
      job_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      seq_ll_r     <= {SEQ_LL_BITS{1'b0}};
      seq_ml_r     <= {SEQ_ML_BITS{1'b0}};
      seq_offset_r <= {SEQ_OFFSET_BITS{1'b0}};
      seq_eoj_r    <= 1'b0;
      seq_delim_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      seq_head_r   <= seq_head_nxt_s;
      match_head_r <= match_head_nxt_s;
      overlap_r    <= overlap_nxt_s;
      delim_r      <= delim_nxt_s;
      ret_issue_r  <= ret_issue_nxt_s;
      req_valid_r  <= req_valid_nxt_s;
      seq_valid_r  <= seq_valid_nxt_s;
      job_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r       <= (state_nxt_s != ST_IDLE);
      seq_ll_r     <= seq_ll_nxt_s;
      seq_ml_r     <= seq_ml_nxt_s;
      seq_offset_r <= seq_offset_nxt_s;
      seq_eoj_r    <= seq_eoj_nxt_s;
      seq_delim_r  <= seq_delim_nxt_s;
    end
  end

endmodule

// File: tb/tb_lazy_job_controller.sv
// Bench for lazy_job_controller: plays scheduler, match engine and sequence sink, and
// checks every request/sequence handshake against a job-level reference model.
module tb_lazy_job_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_job_valid = 1'b0, i_job_delim = 1'b0;
  logic        o_job_ready, o_req_valid, o_req_delim, o_seq_valid, o_seq_eoj, o_seq_delim, o_busy;
  logic        i_req_ready = 1'b0, i_seq_ready = 1'b0;
  logic [5:0]  o_req_match_head_ptr, o_req_seq_head_ptr;
  logic        i_summary_done = 1'b0, i_summary_eoj = 1'b0, i_summary_move_to_next_job = 1'b0;
  logic [5:0]  i_summary_seq_head_ptr = 6'd0, i_summary_move_forward = 6'd0;
  logic [15:0] i_summary_ll = 16'd0, i_summary_ml = 16'd0, i_summary_offset = 16'd0;
  logic [15:0] i_summary_overlap_len = 16'd0;
  logic [15:0] o_seq_ll, o_seq_ml, o_seq_offset;

  lazy_job_controller dut (
    .clk(clk), .rst(rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_delim(i_job_delim),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_match_head_ptr(o_req_match_head_ptr), .o_req_seq_head_ptr(o_req_seq_head_ptr),
    .o_req_delim(o_req_delim),
    .i_summary_done(i_summary_done), .i_summary_seq_head_ptr(i_summary_seq_head_ptr),
    .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml), .i_summary_offset(i_summary_offset),
    .i_summary_eoj(i_summary_eoj), .i_summary_overlap_len(i_summary_overlap_len),
    .i_summary_move_to_next_job(i_summary_move_to_next_job),
    .i_summary_move_forward(i_summary_move_forward),
    .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready),
    .o_seq_ll(o_seq_ll), .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset),
    .o_seq_eoj(o_seq_eoj), .o_seq_delim(o_seq_delim), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { int sh; int mh; int d; } req_t;
  typedef struct { int ll; int ml; int off; int eoj; int d; } seq_t;

  req_t exp_req[$];
  seq_t exp_seq[$];
  int   n_checks = 0, n_fail = 0;
  // Reference model: job-level pointers and carried overlap.
  int   m_seq = 0, m_match = 0, m_ovl = 0, m_delim = 0, last_ll = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req();
    exp_req.push_back('{sh: m_seq, mh: m_match, d: m_delim});
  endtask

  task automatic push_seq(input int ll, input int ml, input int off, input int eoj, input int d);
    exp_seq.push_back('{ll: ll, ml: ml, off: off, eoj: eoj, d: d});
    last_ll = ll;
  endtask

  task automatic rand_summary_fields();
    i_summary_seq_head_ptr     = 6'($urandom);
    i_summary_ll               = 16'($urandom);
    i_summary_ml               = 16'($urandom);
    i_summary_offset           = 16'($urandom);
    i_summary_eoj              = 1'($urandom);
    i_summary_overlap_len      = 16'($urandom);
    i_summary_move_to_next_job = 1'($urandom);
    i_summary_move_forward     = 6'($urandom);
  endtask

  // Stray summaries while not waiting must be ignored by the controller.
  task automatic maybe_stray();
    if ($urandom_range(0, 7) == 0) begin
      rand_summary_fields();
      i_summary_done = 1'b1;
    end else begin
      i_summary_done = 1'b0;
    end
  endtask

  task automatic offer_job(input int d, output bit skipped);
    int n = 0;
    bit ok = 1'b0;
    @(negedge clk);
    chk("idle_job_ready", 32'(o_job_ready), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_job_valid = 1'b1;
    i_job_delim = 1'(d);
    while (!ok && n < 50) begin
      @(negedge clk);
      if (o_job_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    i_job_valid = 1'b0;
    chk("job_accept_timeout", 32'(ok), 32'd1);
    m_delim = d;
    if (m_ovl >= 64) begin
      push_seq(0, 0, 0, 1, d);
      m_ovl = (d != 0) ? 0 : m_ovl - 64;
      skipped = 1'b1;
    end else begin
      m_seq = m_ovl;
      m_match = m_ovl;
      m_ovl = 0;
      push_req();
      skipped = 1'b0;
    end
  endtask

  task automatic wait_req(input int stall);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 200) begin
      i_req_ready = (n >= stall) && ($urandom_range(0, 2) != 0);
      maybe_stray();
      @(negedge clk);
      if (o_req_valid && i_req_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    i_req_ready = 1'b0;
    i_summary_done = 1'b0;
    chk("req_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_seq(input int stall);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 200) begin
      i_seq_ready = (n >= stall) && ($urandom_range(0, 2) != 0);
      maybe_stray();
      @(negedge clk);
      if (o_seq_valid && i_seq_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    i_seq_ready = 1'b0;
    i_summary_done = 1'b0;
    chk("seq_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_summary(input int ll, input int ml, input int off, input int eoj,
                              input int ovl, input int mtnj, input int mf,
                              output bit done, output bit had_seq, output bit had_req);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("wait_busy", 32'(o_busy), 32'd1);
      chk("wait_job_ready", 32'(o_job_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_summary_seq_head_ptr     = 6'(m_seq);
    i_summary_ll               = 16'(ll);
    i_summary_ml               = 16'(ml);
    i_summary_offset           = 16'(off);
    i_summary_eoj              = 1'(eoj);
    i_summary_overlap_len      = 16'(ovl);
    i_summary_move_to_next_job = 1'(mtnj);
    i_summary_move_forward     = 6'(mf);
    i_summary_done             = 1'b1;
    done = 1'b0; had_seq = 1'b0; had_req = 1'b0;
    if (ml == 0 && eoj == 0) begin
      if (m_match + 4 < 64) begin
        m_match += 4;
        push_req(); had_req = 1'b1;
      end else begin
        push_seq(64 - m_seq, 0, 0, 1, m_delim); had_seq = 1'b1;
        m_ovl = 0; done = 1'b1;
      end
    end else if (mtnj != 0) begin
      push_seq(ll, ml, off, 1, m_delim); had_seq = 1'b1;
      m_ovl = (m_delim != 0) ? 0 : ovl;
      done = 1'b1;
    end else begin
      push_seq(ll, ml, off, 0, 0); had_seq = 1'b1;
      m_seq += mf;
      m_match = m_seq;
      chk("contract_head_in_job", 32'(m_seq < 64), 32'd1);
      push_req(); had_req = 1'b1;
    end
    @(posedge clk); #1;
    i_summary_done = 1'b0;
  endtask

  task automatic follow(input bit had_seq, input bit had_req, input int stall);
    if (had_seq) wait_seq(stall);
    if (had_req) wait_req(stall);
  endtask

  // Compare process: handshakes against the model, stability under backpressure, gaps.
  bit   p_req_stall = 1'b0, p_seq_stall = 1'b0, p_seq_hs = 1'b0;
  logic [5:0]  p_sh, p_mh;
  logic        p_rd, p_eoj, p_sd;
  logic [15:0] p_ll, p_ml, p_off;
  req_t er;
  seq_t es;
  always @(negedge clk) begin
    if (rst) begin
      p_req_stall = 1'b0; p_seq_stall = 1'b0; p_seq_hs = 1'b0;
    end else begin
      chk("req_unexpected", 32'(o_req_valid && (exp_req.size() == 0)), 32'd0);
      chk("seq_unexpected", 32'(o_seq_valid && (exp_seq.size() == 0)), 32'd0);
      if (p_req_stall) begin
        chk("req_hold_valid", 32'(o_req_valid), 32'd1);
        chk("req_hold_seq", 32'(o_req_seq_head_ptr), 32'(p_sh));
        chk("req_hold_match", 32'(o_req_match_head_ptr), 32'(p_mh));
        chk("req_hold_delim", 32'(o_req_delim), 32'(p_rd));
      end
      if (o_req_valid && i_req_ready && exp_req.size() > 0) begin
        er = exp_req.pop_front();
        chk("req_seq_head", 32'(o_req_seq_head_ptr), 32'(er.sh));
        chk("req_match_head", 32'(o_req_match_head_ptr), 32'(er.mh));
        chk("req_delim", 32'(o_req_delim), 32'(er.d));
      end
      p_req_stall = o_req_valid && !i_req_ready;
      p_sh = o_req_seq_head_ptr; p_mh = o_req_match_head_ptr; p_rd = o_req_delim;
      if (p_seq_hs) chk("seq_gap", 32'(o_seq_valid), 32'd0);
      if (p_seq_stall) begin
        chk("seq_hold_valid", 32'(o_seq_valid), 32'd1);
        chk("seq_hold_ll", 32'(o_seq_ll), 32'(p_ll));
        chk("seq_hold_ml", 32'(o_seq_ml), 32'(p_ml));
        chk("seq_hold_off", 32'(o_seq_offset), 32'(p_off));
        chk("seq_hold_eoj", 32'(o_seq_eoj), 32'(p_eoj));
        chk("seq_hold_delim", 32'(o_seq_delim), 32'(p_sd));
      end
      if (o_seq_valid && i_seq_ready && exp_seq.size() > 0) begin
        es = exp_seq.pop_front();
        chk("seq_ll", 32'(o_seq_ll), 32'(es.ll));
        chk("seq_ml", 32'(o_seq_ml), 32'(es.ml));
        chk("seq_offset", 32'(o_seq_offset), 32'(es.off));
        chk("seq_eoj", 32'(o_seq_eoj), 32'(es.eoj));
        chk("seq_delim", 32'(o_seq_delim), 32'(es.d));
      end
      p_seq_hs = o_seq_valid && i_seq_ready;
      p_seq_stall = o_seq_valid && !i_seq_ready;
      p_ll = o_seq_ll; p_ml = o_seq_ml; p_off = o_seq_offset; p_eoj = o_seq_eoj; p_sd = o_seq_delim;
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit sk, dn, hs, hr;
    int g, kind, ll, ml, mf, top;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", 32'(o_job_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_req_valid", 32'(o_req_valid), 32'd0);
    chk("rst_seq_valid", 32'(o_seq_valid), 32'd0);
    chk("rst_req_ptrs", 32'({o_req_seq_head_ptr, o_req_match_head_ptr, o_req_delim}), 32'd0);
    chk("rst_seq_fields", 32'(|{o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Job 1: one match, then lazy windows sliding to the job end.
    offer_job(0, sk);
    wait_req(0);
    send_summary(3, 8, 100, 0, 0, 0, 11, dn, hs, hr);
    chk("pin_head_11", 32'(m_seq), 32'd11);
    follow(hs, hr, 5);
    send_summary(0, 0, 0, 0, 0, 0, 0, dn, hs, hr);
    chk("pin_match_15", 32'(m_match), 32'd15);
    follow(hs, hr, 0);
    send_summary(0, 0, 0, 0, 0, 0, 0, dn, hs, hr);
    chk("pin_match_19", 32'(m_match), 32'd19);
    chk("pin_seq_stays_11", 32'(m_seq), 32'd11);
    follow(hs, hr, 0);
    g = 0;
    dn = 1'b0;
    while (!dn && g < 20) begin
      send_summary(0, 0, 0, 0, 0, 0, 0, dn, hs, hr);
      follow(hs, hr, 0);
      g++;
    end
    chk("pin_term_ll_53", 32'(last_ll), 32'd53);

    // Overlap carry, whole-job skip, and carry after a skip.
    offer_job(0, sk);
    chk("pin_next_head_0", 32'(m_seq), 32'd0);
    wait_req(0);
    send_summary(10, 7, 33, 1, 5, 1, 0, dn, hs, hr);
    follow(hs, hr, 0);
    offer_job(0, sk);
    chk("pin_head_5", 32'(m_seq), 32'd5);
    wait_req(0);
    send_summary(20, 40, 9, 1, 70, 1, 0, dn, hs, hr);
    follow(hs, hr, 0);
    offer_job(0, sk);
    chk("pin_skip", 32'(sk), 32'd1);
    chk("pin_ovl_6", 32'(m_ovl), 32'd6);
    wait_seq(3);
    offer_job(0, sk);
    chk("pin_head_6", 32'(m_seq), 32'd6);
    wait_req(0);

    // Reset while waiting for a summary.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstwait_busy", 32'(o_busy), 32'd0);
    chk("rstwait_job_ready", 32'(o_job_ready), 32'd1);
    chk("rstwait_req_valid", 32'(o_req_valid), 32'd0);
    chk("rstwait_seq_valid", 32'(o_seq_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ovl = 0;
    exp_req.delete();
    exp_seq.delete();

    // Delimited job drops its carried overlap.
    offer_job(1, sk);
    wait_req(0);
    send_summary(4, 50, 7, 1, 30, 1, 0, dn, hs, hr);
    chk("pin_delim_ovl_0", 32'(m_ovl), 32'd0);
    follow(hs, hr, 0);

    // Randomized jobs.
    for (int j = 0; j < 60; j++) begin
      offer_job(($urandom_range(0, 3) == 0) ? 1 : 0, sk);
      if (sk) begin
        wait_seq($urandom_range(0, 2));
      end else begin
        dn = 1'b0;
        g = 0;
        wait_req($urandom_range(0, 2));
        while (!dn && g < 40) begin
          kind = $urandom_range(0, 9);
          if (kind < 3) begin
            send_summary(0, 0, 0, 0, 0, 0, 0, dn, hs, hr);
          end else if (kind < 8 && m_seq < 63) begin
            top = (63 - m_seq < 20) ? 63 - m_seq : 20;
            mf = $urandom_range(1, top);
            ll = $urandom_range(0, mf - 1);
            ml = mf - ll;
            send_summary(ll, ml, $urandom_range(1, 65535), 0, 0, 0, mf, dn, hs, hr);
          end else begin
            send_summary($urandom_range(0, 63), $urandom_range(0, 40), $urandom_range(0, 65535),
                         1, $urandom_range(0, 140), 1, $urandom_range(0, 63), dn, hs, hr);
          end
          follow(hs, hr, $urandom_range(0, 2));
          g++;
        end
      end
    end

    repeat (3) @(posedge clk);
    chk("drain_req_queue", 32'(exp_req.size()), 32'd0);
    chk("drain_seq_queue", 32'(exp_seq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
